// File: rtl/gcd_pkg.sv
// Shared types for the GCD driver: operand width, FSM state encoding and
// the operand pair carried through the driver's input FIFO.
package gcd_pkg;

    localparam int GCD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } gcd_drv_state_t;

    typedef struct packed {
        logic [GCD_W-1:0] x;
        logic [GCD_W-1:0] y;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_drv_fifo.sv
// Operand-pair FIFO for gcd_driver. Synchronous read/write, one extra
// pointer bit distinguishes full from empty. Pushes while full and pops
// while empty are dropped, so the storage is never corrupted. Read data is
// the word at the read pointer; a word written at one edge becomes visible
// for popping only after that edge (no write-to-read bypass).
module gcd_drv_fifo
    import gcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  gcd_pair_t wr_data,
    output gcd_pair_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    gcd_pair_t   mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; both wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/gcd_driver.sv
// gcd_driver: feeds operand pairs from a valid/ready stream into a GCD core
// using the core's start/rdy protocol and returns results on a valid/ready
// output stream. One transaction is in flight at a time; further pairs wait
// in gcd_drv_fifo.
// Optional feature: define GCD_DRV_TIMEOUT_EN to abort runs that exceed
// TIMEOUT cycles (result 0 with out_err=1, and a one-cycle core_rst pulse).
// W is expected to match gcd_pkg::GCD_W, the width of the FIFO pair.
//
// State | Meaning
// IDLE  | waiting for a queued pair; pops and registers it onto core_xi/yi
// LOAD  | core_start low, operands stable for LOAD_CYC cycles
// RUN   | core_start high, waiting for core_rdy (or timeout when enabled)
// DONE  | result held on out_gcd/out_err until out_valid & out_ready
module gcd_driver
    import gcd_pkg::*;
#(
    parameter int W        = GCD_W,
    parameter int DEPTH    = 4,
    parameter int LOAD_CYC = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic [W-1:0] core_xi,
    output logic [W-1:0] core_yi,
    output logic         core_start,
    output logic         core_rst,
    input  logic         core_rdy,
    input  logic [W-1:0] core_xo,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic         out_err
);

    localparam int             LCW       = $clog2(LOAD_CYC + 1);
    localparam logic [LCW-1:0] LOAD_INIT = LCW'(LOAD_CYC - 1);

    gcd_drv_state_t state, state_n;
    logic [LCW-1:0] load_cnt, load_cnt_n;
    logic [W-1:0]   xi_n, yi_n, gcd_n;
    logic           start_n, valid_n, crst_n;
    logic           in_en;
    logic           fifo_full, fifo_empty, fifo_pop, fifo_push;
    gcd_pair_t      wr_pair, rd_pair;

`ifdef GCD_DRV_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_INIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          err_q, err_n;

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    // in_en keeps in_ready low through reset without a path from rst itself.
    assign in_ready  = in_en && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign wr_pair.x = GCD_W'(in_x);
    assign wr_pair.y = GCD_W'(in_y);

    gcd_drv_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (wr_pair),
        .rd_data (rd_pair),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            load_cnt   <= '0;
            core_xi    <= '0;
            core_yi    <= '0;
            core_start <= 1'b0;
            core_rst   <= 1'b1;
            out_valid  <= 1'b0;
            out_gcd    <= '0;
            in_en      <= 1'b0;
`ifdef GCD_DRV_TIMEOUT_EN
            to_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            load_cnt   <= load_cnt_n;
            core_xi    <= xi_n;
            core_yi    <= yi_n;
            core_start <= start_n;
            core_rst   <= crst_n;
            out_valid  <= valid_n;
            out_gcd    <= gcd_n;
            in_en      <= 1'b1;
`ifdef GCD_DRV_TIMEOUT_EN
            to_cnt     <= to_cnt_n;
            err_q      <= err_n;
`endif
        end
    end

    // Next-state and next-output logic; counters are down-counters that
    // finish on reaching zero.
    always_comb begin
        state_n    = state;
        load_cnt_n = load_cnt;
        xi_n       = core_xi;
        yi_n       = core_yi;
        start_n    = core_start;
        valid_n    = out_valid;
        gcd_n      = out_gcd;
        crst_n     = 1'b0;
        fifo_pop   = 1'b0;
`ifdef GCD_DRV_TIMEOUT_EN
        to_cnt_n   = to_cnt;
        err_n      = err_q;
`endif
        case (state)
            IDLE: begin
                start_n = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    xi_n       = W'(rd_pair.x);
                    yi_n       = W'(rd_pair.y);
                    load_cnt_n = LOAD_INIT;
                    state_n    = LOAD;
                end
            end
            LOAD: begin
                // core_rdy is not looked at here: the core drops stale rdy
                // while start is low.
                start_n = 1'b0;
                if (load_cnt == '0) begin
                    start_n = 1'b1;
                    state_n = RUN;
`ifdef GCD_DRV_TIMEOUT_EN
                    to_cnt_n = TO_INIT;
`endif
                end else begin
                    load_cnt_n = load_cnt - LCW'(1);
                end
            end
            RUN: begin
                start_n = 1'b1;
                if (core_rdy) begin
                    gcd_n   = core_xo;
                    valid_n = 1'b1;
                    start_n = 1'b0;
                    state_n = DONE;
`ifdef GCD_DRV_TIMEOUT_EN
                    err_n   = 1'b0;
                end else if (to_cnt == '0) begin
                    gcd_n   = '0;
                    err_n   = 1'b1;
                    valid_n = 1'b1;
                    start_n = 1'b0;
                    crst_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    to_cnt_n = to_cnt - TW'(1);
`endif
                end
            end
            DONE: begin
                start_n = 1'b0;
                if (out_valid && out_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                start_n = 1'b0;
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver: a behavioural GCD core answers the start/rdy
// protocol with random latency; expected results come from a Euclid
// reference applied to the pushed operands, kept in push order.
module tb_gcd_driver;

    localparam int W          = 16;
    localparam int DEPTH      = 4;
    localparam int LOAD_CYC   = 2;
    localparam int TIMEOUT_TB = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_x = '0;
    logic [W-1:0] in_y = '0;
    logic [W-1:0] core_xi, core_yi;
    logic         core_start, core_rst;
    logic         core_rdy = 1'b0;
    logic [W-1:0] core_xo = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_gcd;
    logic         out_err;

    int           n_checks = 0;
    int           n_pass   = 0;
    bit           never_rdy = 1'b0;
    int           lat = 0;
    logic [W-1:0] exp_q [$];

    gcd_driver #(
        .W        (W),
        .DEPTH    (DEPTH),
        .LOAD_CYC (LOAD_CYC),
        .TIMEOUT  (TIMEOUT_TB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .core_xi    (core_xi),
        .core_yi    (core_yi),
        .core_start (core_start),
        .core_rst   (core_rst),
        .core_rdy   (core_rdy),
        .core_xo    (core_xo),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gcd    (out_gcd),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    // Reference result: gcd of magnitudes by Euclid, zero if either is zero.
    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
        int a, b, t;
        a = int'($signed(x));
        b = int'($signed(y));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        if (a == 0 || b == 0) return '0;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a[W-1:0];
    endfunction

    // Core's own arithmetic: repeated subtraction.
    function automatic logic [W-1:0] core_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        int a, b;
        a = int'($signed(x));
        b = int'($signed(y));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        if (a == 0 || b == 0) return '0;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
        end
        return a[W-1:0];
    endfunction

    // Behavioural core: clears rdy while start is low, answers after a
    // random latency while start is high.
    always @(posedge clk) begin
        if (core_rst || !core_start) begin
            core_rdy <= 1'b0;
            lat      <= $urandom_range(0, 4);
        end else if (!core_rdy && !never_rdy) begin
            if (lat == 0) begin
                core_xo  <= core_gcd(core_xi, core_yi);
                core_rdy <= 1'b1;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = W'($urandom_range(0, 150) * $urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
        bit r;
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i > 0) @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        #1 in_valid = 1'b0;
        n_checks++;
        if (ok) begin
            n_pass++;
            exp_q.push_back(gcd_ref(x, y));
        end else begin
            $display("FAIL push_accept: pair %0h,%0h accepted=%0d required=1", x, y, ok);
        end
    endtask

    task automatic collect(input int n, input int pct, input int budget);
        int got;
        logic [W-1:0] e;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 99) < pct);
            if (out_valid && out_ready) begin
                got++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_result: out_gcd=%0h with nothing queued", out_gcd);
                end else begin
                    e = exp_q.pop_front();
                    if (out_gcd !== e)
                        $display("FAIL result_gcd: out_gcd=%0h required=%0h", out_gcd, e);
                    else
                        n_pass++;
                end
                n_checks++;
                if (out_err !== 1'b0) $display("FAIL result_err: out_err=%0b required=0", out_err);
                else n_pass++;
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_checks++;
        if (got !== n) $display("FAIL collect_count: got=%0d required=%0d", got, n);
        else n_pass++;
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (core_start) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL start_seen: core_start never rose");
        else n_pass++;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, core_rst, core_start, out_valid, out_err} !== 5'b01000)
            $display("FAIL reset_ctrl: {in_ready,core_rst,core_start,out_valid,out_err}=%b required=01000",
                     {in_ready, core_rst, core_start, out_valid, out_err});
        else n_pass++;
        n_checks++;
        if ({core_xi, core_yi, out_gcd} !== '0)
            $display("FAIL reset_data: xi=%0h yi=%0h gcd=%0h required=0", core_xi, core_yi, out_gcd);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, core_rst} !== 2'b10)
            $display("FAIL reset_release: {in_ready,core_rst}=%b required=10", {in_ready, core_rst});
        else n_pass++;
    endtask

    task automatic test_basic();
        int k;
        push(16'd12, 16'd18);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (core_start) break;
        end
        n_checks++;
        if (k !== LOAD_CYC + 1) $display("FAIL start_latency: edges=%0d required=%0d", k, LOAD_CYC + 1);
        else n_pass++;
        n_checks++;
        if ({core_xi, core_yi} !== {16'd12, 16'd18})
            $display("FAIL operands: xi=%0d yi=%0d required=12,18", core_xi, core_yi);
        else n_pass++;
        collect(1, 100, 100);
    endtask

    task automatic test_zero();
        push(16'd0, 16'd5);
        collect(1, 100, 100);
        push(16'hFFF4, 16'd18);
        collect(1, 100, 100);
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    push(rand_op(), rand_op());
                end
            end
            collect(20, 60, 3000);
        join
    endtask

    task automatic test_full_fifo();
        logic [W-1:0] px [6];
        logic [W-1:0] py [6];
        int acc;
        bit r;
        for (int i = 0; i < 6; i++) begin
            px[i] = rand_op();
            py[i] = rand_op();
        end
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20 && acc < 6; c++) begin
            @(negedge clk);
            in_x = px[acc];
            in_y = py[acc];
            in_valid = 1'b1;
            r = in_ready;
            if (!r) break;
            @(posedge clk);
            exp_q.push_back(gcd_ref(px[acc], py[acc]));
            acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (acc !== 5) $display("FAIL full_accepts: accepted=%0d required=5", acc);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL full_hold: in_ready=%0b required=0", in_ready);
        else n_pass++;
        fork
            push(px[5], py[5]);
            collect(6, 100, 600);
        join
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ax;
        logic [W-1:0] e;
        bit seen;
        ax = rand_op();
        out_ready = 1'b0;
        push(ax, rand_op());
        push(rand_op(), rand_op());
        e = exp_q[0];
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL bp_valid: out_valid never rose");
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid, core_start, out_gcd, core_xi} !== {1'b1, 1'b0, e, ax})
                $display("FAIL bp_hold: valid=%0b start=%0b gcd=%0h xi=%0h required 1,0,%0h,%0h",
                         out_valid, core_start, out_gcd, core_xi, e, ax);
            else n_pass++;
        end
        collect(2, 100, 200);
    endtask

    task automatic test_timeout();
        bit seen;
        int k;
        never_rdy = 1'b1;
        push(16'd7, 16'd21);
        wait_start(seen);
`ifdef GCD_DRV_TIMEOUT_EN
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (out_valid) break;
        end
        n_checks++;
        if (k !== TIMEOUT_TB) $display("FAIL timeout_cycles: cycles=%0d required=%0d", k, TIMEOUT_TB);
        else n_pass++;
        n_checks++;
        if ({out_err, out_gcd, core_start, core_rst} !== {1'b1, 16'd0, 1'b0, 1'b1})
            $display("FAIL timeout_out: err=%0b gcd=%0h start=%0b core_rst=%0b required 1,0,0,1",
                     out_err, out_gcd, core_start, core_rst);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({core_rst, out_valid, out_err} !== 3'b011)
            $display("FAIL timeout_pulse: core_rst=%0b valid=%0b err=%0b required 0,1,1", core_rst, out_valid, out_err);
        else n_pass++;
        void'(exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL timeout_ack: out_valid=%0b required=0", out_valid);
        else n_pass++;
        never_rdy = 1'b0;
`else
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (core_start && !out_valid) k++;
        end
        n_checks++;
        if (k !== 100) $display("FAIL no_timeout: cycles_in_run=%0d required=100", k);
        else n_pass++;
        n_checks++;
        if ({core_start, out_valid, out_err} !== 3'b100)
            $display("FAIL no_timeout_out: start=%0b valid=%0b err=%0b required 1,0,0", core_start, out_valid, out_err);
        else n_pass++;
        void'(exp_q.pop_front());
`endif
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        int bad;
        never_rdy = 1'b1;
        if (!core_start) begin
            push(16'd9, 16'd6);
            wait_start(seen);
        end
        for (int i = 0; i < 3; i++) push(rand_op(), rand_op());
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, core_rst, core_start, out_valid, out_err} !== 5'b01000)
            $display("FAIL midrst_ctrl: {in_ready,core_rst,core_start,out_valid,out_err}=%b required=01000",
                     {in_ready, core_rst, core_start, out_valid, out_err});
        else n_pass++;
        n_checks++;
        if ({core_xi, core_yi, out_gcd} !== '0)
            $display("FAIL midrst_data: xi=%0h yi=%0h gcd=%0h required=0", core_xi, core_yi, out_gcd);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        never_rdy = 1'b0;
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || core_start || core_xi != '0) bad++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (bad !== 0) $display("FAIL midrst_quiet: active_cycles=%0d required=0", bad);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midrst_ready: in_ready=%0b required=1", in_ready);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_random();
        test_full_fifo();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
